// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the single register-file write port between the MEM/WB
//   pipeline stage and a long-latency unit (mul/div). The pipeline normally
//   wins; a pending long-latency result is forced through after losing
//   MAX_WAIT consecutive cycles, stalling the pipeline for that one cycle.
//   Grant, out_lu_ready and out_pipe_stall are combinational; the
//   register-file write (enable/address/data) is registered, latency 1.
//
// Parameters
//   MAX_WAIT (1..15)  consecutive cycles a pending LU write may lose
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   in_pipe_write_enable/rd      MEM/WB write request and destination
//   in_pipe_mem_to_reg           selects mem_out (1) or alu_out (0)
//   in_pipe_alu_out/mem_out      pipeline write data candidates
//   in_lu_valid/rd/data          long-latency result (held until ready)
//   out_lu_ready                 LU result consumed this cycle
//   out_pipe_stall               hold MEM/WB and upstream this cycle
//   out_rf_write_enable/rd/data  registered register-file write
//
// Optional feature (macro WB_ARB_PERF_EN)
//   out_stall_cycles  cycles with out_pipe_stall=1 (wraps mod 2^32)
//   out_lu_writes     LU grants (wraps mod 2^32)
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_pipe_write_enable,
  input  logic [4:0]  in_pipe_rd,
  input  logic        in_pipe_mem_to_reg,
  input  logic [31:0] in_pipe_alu_out,
  input  logic [31:0] in_pipe_mem_out,
  input  logic        in_lu_valid,
  input  logic [4:0]  in_lu_rd,
  input  logic [31:0] in_lu_data,
  output logic        out_lu_ready,
  output logic        out_pipe_stall,
  output logic        out_rf_write_enable,
  output logic [4:0]  out_rf_rd,
  output logic [31:0] out_rf_data
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] out_stall_cycles,
  output logic [31:0] out_lu_writes
`endif
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LU
  } grant_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  grant_t      grant;
  logic        pipe_req;
  logic        lu_req;
  logic [31:0] pipe_data;
  logic [3:0]  wait_cnt;

  // Writes to x0 are never real requests.
  assign pipe_req  = in_pipe_write_enable && (in_pipe_rd != '0);
  assign lu_req    = in_lu_valid && (in_lu_rd != '0);
  assign pipe_data = in_pipe_mem_to_reg ? in_pipe_mem_out : in_pipe_alu_out;

  // Gated by reset so nothing is granted or acknowledged while in reset.
  always_comb begin
    grant          = GNT_NONE;
    out_lu_ready   = 1'b0;
    out_pipe_stall = 1'b0;
    if (!reset) begin
      if (lu_req && (!pipe_req || wait_cnt == WAIT_LIMIT)) begin
        grant = GNT_LU;
      end else if (pipe_req) begin
        grant = GNT_PIPE;
      end
      // An x0-targeted LU result is dropped by acknowledging it without a write.
      out_lu_ready   = (grant == GNT_LU) || (in_lu_valid && in_lu_rd == '0);
      out_pipe_stall = pipe_req && (grant == GNT_LU);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt            <= '0;
      out_rf_write_enable <= 1'b0;
      out_rf_rd           <= '0;
      out_rf_data         <= '0;
    end else begin
      // lu_req without an LU grant implies the pipe won this cycle.
      if (grant == GNT_LU || !lu_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      unique case (grant)
        GNT_LU: begin
          out_rf_write_enable <= 1'b1;
          out_rf_rd           <= in_lu_rd;
          out_rf_data         <= in_lu_data;
        end
        GNT_PIPE: begin
          out_rf_write_enable <= 1'b1;
          out_rf_rd           <= in_pipe_rd;
          out_rf_data         <= pipe_data;
        end
        default: begin
          out_rf_write_enable <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_stall_cycles <= '0;
      out_lu_writes    <= '0;
    end else begin
      if (out_pipe_stall) out_stall_cycles <= out_stall_cycles + 32'd1;
      if (grant == GNT_LU) out_lu_writes   <= out_lu_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: two instances (MAX_WAIT=4 and MAX_WAIT=1)
// share stimulus; a behavioural model tracks expected outputs for both.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pwe;
  logic [4:0]  prd;
  logic        m2r;
  logic [31:0] alu;
  logic [31:0] mem;
  logic        lv;
  logic [4:0]  lrd;
  logic [31:0] ld;

  logic        rdy [2];
  logic        stl [2];
  logic        we  [2];
  logic [4:0]  rd  [2];
  logic [31:0] dat [2];
`ifdef WB_ARB_PERF_EN
  logic [31:0] sc  [2];
  logic [31:0] lw  [2];
`endif

  wb_port_arbiter #(.MAX_WAIT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_pipe_write_enable(pwe), .in_pipe_rd(prd), .in_pipe_mem_to_reg(m2r),
    .in_pipe_alu_out(alu), .in_pipe_mem_out(mem),
    .in_lu_valid(lv), .in_lu_rd(lrd), .in_lu_data(ld),
    .out_lu_ready(rdy[0]), .out_pipe_stall(stl[0]),
    .out_rf_write_enable(we[0]), .out_rf_rd(rd[0]), .out_rf_data(dat[0])
`ifdef WB_ARB_PERF_EN
    , .out_stall_cycles(sc[0]), .out_lu_writes(lw[0])
`endif
  );

  wb_port_arbiter #(.MAX_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_pipe_write_enable(pwe), .in_pipe_rd(prd), .in_pipe_mem_to_reg(m2r),
    .in_pipe_alu_out(alu), .in_pipe_mem_out(mem),
    .in_lu_valid(lv), .in_lu_rd(lrd), .in_lu_data(ld),
    .out_lu_ready(rdy[1]), .out_pipe_stall(stl[1]),
    .out_rf_write_enable(we[1]), .out_rf_rd(rd[1]), .out_rf_data(dat[1])
`ifdef WB_ARB_PERF_EN
    , .out_stall_cycles(sc[1]), .out_lu_writes(lw[1])
`endif
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state, per instance.
  int          losses   [2];
  logic        m_we     [2];
  logic [4:0]  m_rd     [2];
  logic [31:0] m_data   [2];
  int unsigned m_stalls [2];
  int unsigned m_luw    [2];
  logic        e_rdy    [2];
  logic        e_stl    [2];
  logic        e_luwin  [2];
  logic        e_pwin   [2];

  function automatic int maxw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    pwe = 1'b0; prd = '0; m2r = 1'b0; alu = '0; mem = '0;
    lv = 1'b0; lrd = '0; ld = '0;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next
  // falling edge. Checks combinational outputs before the rising edge and the
  // registered outputs just after it.
  task automatic step();
    logic preq, lreq;
    preq = pwe && (prd != 5'd0);
    lreq = lv && (lrd != 5'd0);
    for (int i = 0; i < 2; i++) begin
      e_luwin[i] = !reset && lreq && (!preq || losses[i] >= maxw(i));
      e_pwin[i]  = !reset && !e_luwin[i] && preq;
      e_rdy[i]   = !reset && (e_luwin[i] || (lv && lrd == 5'd0));
      e_stl[i]   = preq && e_luwin[i];
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.lu_ready", i), 32'(rdy[i]), 32'(e_rdy[i]));
      chk($sformatf("u%0d.pipe_stall", i), 32'(stl[i]), 32'(e_stl[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_we[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0;
        losses[i] = 0; m_stalls[i] = 0; m_luw[i] = 0;
      end else begin
        if (e_luwin[i]) begin
          m_we[i] = 1'b1; m_rd[i] = lrd; m_data[i] = ld; m_luw[i]++;
        end else if (e_pwin[i]) begin
          m_we[i] = 1'b1; m_rd[i] = prd; m_data[i] = m2r ? mem : alu;
        end else begin
          m_we[i] = 1'b0;
        end
        if (e_stl[i]) m_stalls[i]++;
        if (e_luwin[i] || !lreq) losses[i] = 0;
        else if (losses[i] < maxw(i)) losses[i]++;
      end
      chk($sformatf("u%0d.rf_we", i), 32'(we[i]), 32'(m_we[i]));
      chk($sformatf("u%0d.rf_rd", i), 32'(rd[i]), 32'(m_rd[i]));
      chk($sformatf("u%0d.rf_data", i), dat[i], m_data[i]);
`ifdef WB_ARB_PERF_EN
      chk($sformatf("u%0d.stall_cycles", i), sc[i], m_stalls[i]);
      chk($sformatf("u%0d.lu_writes", i), lw[i], m_luw[i]);
`endif
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        rdy;
    logic        stl;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // pwe prd m2r alu mem | lv lrd ld | rdy stl we rd data
    vecs[0] = '{1'b1, 5'd5,  1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b1, 5'd7, 32'h1234_5678,
                1'b1, 1'b0, 1'b1, 5'd7,  32'h1234_5678};
    vecs[2] = '{1'b1, 5'd9,  1'b0, 32'hA5A5_A5A5, 32'h0BAD_0BAD, 1'b1, 5'd0, 32'h7777_7777,
                1'b1, 1'b0, 1'b1, 5'd9,  32'hA5A5_A5A5};
    vecs[3] = '{1'b1, 5'd0,  1'b0, 32'h5555_5555, 32'h0,         1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd12, 1'b0, 32'h0000_00C0, 32'hFFFF_0000, 1'b1, 5'd3, 32'h0000_0033,
                1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_00C0};
    vecs[5] = '{1'b0, 5'd4,  1'b1, 32'h0,         32'h0,         1'b1, 5'd0, 32'h9999_9999,
                1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[6] = '{1'b1, 5'd31, 1'b0, 32'hFFFF_FFFF, 32'h0123_4567, 1'b0, 5'd8, 32'h0,
                1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF};

    for (int i = 0; i < 2; i++) begin
      losses[i] = 0; m_we[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0;
      m_stalls[i] = 0; m_luw[i] = 0;
    end

    @(negedge clk);
    reset = 1'b1;
    set_idle();
    step();
    step();
    reset = 1'b0;
    step();

    // Table-driven single-transaction vectors, each followed by an idle cycle.
    for (int v = 0; v < 7; v++) begin
      pwe = vecs[v].pwe; prd = vecs[v].prd; m2r = vecs[v].m2r;
      alu = vecs[v].alu; mem = vecs[v].mem;
      lv = vecs[v].lv; lrd = vecs[v].lrd; ld = vecs[v].ld;
      #1;
      chk($sformatf("vec%0d.lu_ready", v), 32'(rdy[0]), 32'(vecs[v].rdy));
      chk($sformatf("vec%0d.pipe_stall", v), 32'(stl[0]), 32'(vecs[v].stl));
      step();
      chk($sformatf("vec%0d.rf_we", v), 32'(we[0]), 32'(vecs[v].we));
      if (vecs[v].we) begin
        chk($sformatf("vec%0d.rf_rd", v), 32'(rd[0]), 32'(vecs[v].rd));
        chk($sformatf("vec%0d.rf_data", v), dat[0], vecs[v].data);
      end
      set_idle();
      step();
    end

    // Continuous contention from a clean reset: LU held on rd=3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      pwe = 1'b1; prd = 5'(c); m2r = 1'b0; alu = 32'(c * 16); mem = '0;
      lv = 1'b1; lrd = 5'd3; ld = 32'hCAFE_0003;
      #1;
      chk($sformatf("cont%0d.u4_stall", c), 32'(stl[0]), 32'((c == 5) || (c == 10)));
      chk($sformatf("cont%0d.u4_ready", c), 32'(rdy[0]), 32'((c == 5) || (c == 10)));
      chk($sformatf("cont%0d.u1_stall", c), 32'(stl[1]), 32'(c % 2 == 0));
      step();
      chk($sformatf("cont%0d.u4_rf_rd", c), 32'(rd[0]),
          ((c == 5) || (c == 10)) ? 32'd3 : 32'(c));
      chk($sformatf("cont%0d.u1_rf_rd", c), 32'(rd[1]), (c % 2 == 0) ? 32'd3 : 32'(c));
    end
`ifdef WB_ARB_PERF_EN
    chk("cont.u4_stall_cycles", sc[0], 32'd2);
    chk("cont.u4_lu_writes", lw[0], 32'd2);
    chk("cont.u1_stall_cycles", sc[1], 32'd5);
    chk("cont.u1_lu_writes", lw[1], 32'd5);
`endif

    // Reset in the middle of contention after three losses.
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pwe = 1'b1; prd = 5'd20; m2r = 1'b1; mem = 32'h2020_2020; alu = '0;
    lv = 1'b1; lrd = 5'd6; ld = 32'h6666_6666;
    for (int c = 0; c < 3; c++) step();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst.lu_ready", 32'(rdy[0]), 32'd0);
      chk("rst.pipe_stall", 32'(stl[0]), 32'd0);
      step();
      chk("rst.rf_we", 32'(we[0]), 32'd0);
      chk("rst.rf_rd", 32'(rd[0]), 32'd0);
      chk("rst.rf_data", dat[0], 32'd0);
    end
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("post_rst%0d.stall", c), 32'(stl[0]), 32'(c == 5));
      step();
      chk($sformatf("post_rst%0d.rf_rd", c), 32'(rd[0]), (c == 5) ? 32'd6 : 32'd20);
    end

    // Randomized traffic; LU and stalled pipe requests held as the protocol requires.
    set_idle();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!(lv && !e_rdy[0])) begin
        lv  = ($urandom_range(0, 2) != 0);
        lrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld  = $urandom;
      end
      if (!e_stl[0]) begin
        pwe = ($urandom_range(0, 3) != 0);
        prd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        m2r = 1'($urandom_range(0, 1));
        alu = $urandom;
        mem = $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
